ram_fill_scan: RTL
==================

# ram_fill_scan

Write/read sequencer sitting directly upstream of the team's 8×8 dual-address RAM. It accepts a byte stream over a valid/ready handshake, writes the bytes into consecutive RAM locations, and once the RAM is full switches to a cyclic read scan. In scan mode it steps the read address with a programmable dwell and flags when read data is stable. It drives the RAM's `we`, `inaddr`, `din` and `outaddr` pins exclusively.

## Interface
- `DW`, default 8: data width.
- `AW`, default 3: address width; depth is 2^AW.
- `DWELL`, default 4: clocks spent on each read address; legal values are 2..255.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream byte valid.
- `in_data` in DW: upstream byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `reload` in 1: single-cycle request to refill the RAM from address 0.
- `we` out 1: RAM write enable (registered).
- `inaddr` out AW: RAM write address (registered).
- `din` out DW: RAM write data (registered).
- `outaddr` out AW: RAM read address (registered).
- `rd_strobe` out 1: pulse; RAM read data for `outaddr` is valid this cycle.
- `scan_wrap` out 1: pulse; `outaddr` advanced from 2^AW−1 to 0.
- `fill_done` out 1: level; high while in SCAN.

## Operation
- FSM has two states, FILL and SCAN. Reset state is FILL.
- **FILL**
  - `in_ready` = 1.
  - Each handshake registers `we`=1, `inaddr`=wr_ptr and `din`=in_data for the next cycle. wr_ptr then increments.
  - Handshake with wr_ptr = 2^AW−1 moves the FSM to SCAN and sets wr_ptr to 0.
  - `outaddr` holds at 0 throughout FILL.
- **SCAN**
  - `in_ready` = 0 and `fill_done` = 1.
  - The dwell counter counts 0..DWELL−1. On the terminal count `outaddr` increments, wrapping modulo 2^AW.
  - `scan_wrap` = 1 in the cycle after the 7→0 step.
- **reload**
  - In SCAN: next state is FILL, wr_ptr = 0, `outaddr` = 0, dwell = 0.
  - In FILL: wr_ptr = 0. A handshake in the same cycle is discarded; `we` stays 0 and that byte is lost.
- `we` is low in every cycle without a preceding accepted, non-discarded handshake.
- `rd_strobe` = 1 when dwell = DWELL−1 and `we` = 0. It is suppressed in the cycle where the final write is still in flight.

## Timing
- **Reset values:** `we`=0, `inaddr`=0, `din`=0, `outaddr`=0, `rd_strobe`=0, `scan_wrap`=0, `fill_done`=0, `in_ready`=1, wr_ptr=0, dwell=0.
- **Write latency:** a handshake at edge N produces `we`/`inaddr`/`din` valid in cycle N+1. The RAM commits the write at edge N+2.
- **Back-to-back:** one byte per clock is sustained in FILL. No bubbles are needed.
- **FILL→SCAN:** the 8th handshake at edge N puts the FSM in SCAN in cycle N+1 while `we` is still 1. The first `rd_strobe` for address 0 occurs at cycle N+DWELL.
- **Address dwell:** each `outaddr` value is held for exactly DWELL cycles. `rd_strobe` fires once per address, in its last dwell cycle.
- **Reset mid-FILL:** partial data stays in the RAM. The next fill restarts at address 0.
- **Idle input:** `in_valid` low in FILL means no state change and `we`=0.

## Structure
- Package `ram_ctrl_pkg` holds:
  - the `state_t` enum {FILL, SCAN};
  - the DW/AW default localparams;
  - the DWELL_MAX constant.
- Sub-module `dwell_timer` (params DWELL; ports clk, rst, clr, en, tc) wraps the dwell counter. All other logic is flat in `ram_fill_scan`.

## Test plan
- **Basic fill:** after reset, send bytes 0x10..0x17 back-to-back. Expect `we` high for 8 consecutive cycles with `inaddr` 0..7 and `din` 0x10..0x17. `fill_done` rises the cycle after the 8th handshake.
- **Scan sequence:** with DWELL=4 after fill, `outaddr` steps 0,1,..,7,0 every 4 cycles. `rd_strobe` fires at the 4th cycle of each address. `scan_wrap` pulses once per 32 cycles.
- **Stalled input:** with `in_valid` toggling 1,0,0,1…, `we` pulses only after accepted bytes, `inaddr` increments by one per accepted byte, and 8 bytes are written.
- **Reload with data:** assert `reload` in FILL at wr_ptr=5 together with `in_valid`, data 0xAA. 0xAA is not written and the next accepted byte goes to `inaddr` 0.
- **Reload in SCAN:** assert `reload` at `outaddr`=3. Next cycle shows `in_ready`=1, `outaddr`=0 and `fill_done`=0.
- **Async reset mid-scan:** all outputs take their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the RAM fill/scan sequencer
//
// Purpose: FSM state type, default data/address widths and the dwell limit
//          used by ram_fill_scan and dwell_timer.
// Ports:   none (package).

package ram_ctrl_pkg;

    typedef enum logic {
        FILL = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 3;
    localparam int DWELL_MAX = 255;

    // Counter width able to hold any legal dwell terminal count.
    localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - modulo-DWELL dwell counter for the read scan
//
// Purpose: counts 0..DWELL-1 while enabled and flags the terminal count.
// Ports:
//   clk  in  : clock
//   rst  in  : asynchronous active-high reset
//   clr  in  : synchronous clear to 0 (wins over en)
//   en   in  : advance the count this cycle
//   tc   out : count is DWELL-1

module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    import ram_ctrl_pkg::*;

    // DWELL is expected in 2..DWELL_MAX.
    localparam logic [DWELL_W-1:0] TC_VAL = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/ram_fill_scan.sv
// rtl/ram_fill_scan.sv - fills the 8x8 RAM from a byte stream then scans it cyclically
//
// Purpose: writes accepted bytes to consecutive RAM addresses; once every
//          location is written, steps the read address with a fixed dwell.
// Ports:
//   clk, rst           in  : clock, asynchronous active-high reset
//   in_valid/in_data   in  : upstream byte stream
//   in_ready           out : high in FILL
//   reload             in  : restart filling from address 0
//   we/inaddr/din      out : registered RAM write port
//   outaddr            out : registered RAM read address
//   rd_strobe          out : read data for outaddr valid this cycle
//   scan_wrap          out : outaddr just wrapped to 0
//   fill_done          out : high while scanning

module ram_fill_scan #(
    parameter int DW    = ram_ctrl_pkg::DW_DEF,
    parameter int AW    = ram_ctrl_pkg::AW_DEF,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          reload,
    output logic          we,
    output logic [AW-1:0] inaddr,
    output logic [DW-1:0] din,
    output logic [AW-1:0] outaddr,
    output logic          rd_strobe,
    output logic          scan_wrap,
    output logic          fill_done
);
    import ram_ctrl_pkg::*;

    localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

    state_t        state_q,     state_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic          we_q,        we_d;
    logic [AW-1:0] inaddr_q,    inaddr_d;
    logic [DW-1:0] din_q,       din_d;
    logic [AW-1:0] outaddr_q,   outaddr_d;
    logic          scan_wrap_q, scan_wrap_d;

    logic          dwell_clr;
    logic          dwell_en;
    logic          dwell_tc;

    // The counter sits at 0 throughout FILL so the first address gets a full dwell.
    assign dwell_clr = reload || (state_q == FILL);
    assign dwell_en  = (state_q == SCAN);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr),
        .en  (dwell_en),
        .tc  (dwell_tc)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        we_d        = 1'b0;
        inaddr_d    = inaddr_q;
        din_d       = din_q;
        outaddr_d   = outaddr_q;
        scan_wrap_d = 1'b0;

        case (state_q)
            FILL: begin
                if (reload) begin
                    // A byte offered alongside reload is accepted but dropped.
                    wr_ptr_d = '0;
                end else if (in_valid) begin
                    we_d     = 1'b1;
                    inaddr_d = wr_ptr_q;
                    din_d    = in_data;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PTR_MAX) begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (reload) begin
                    state_d   = FILL;
                    wr_ptr_d  = '0;
                    outaddr_d = '0;
                end else if (dwell_tc) begin
                    outaddr_d = outaddr_q + 1'b1;
                    if (outaddr_q == PTR_MAX) begin
                        scan_wrap_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            we_q        <= 1'b0;
            inaddr_q    <= '0;
            din_q       <= '0;
            outaddr_q   <= '0;
            scan_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            we_q        <= we_d;
            inaddr_q    <= inaddr_d;
            din_q       <= din_d;
            outaddr_q   <= outaddr_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign fill_done = (state_q == SCAN);
    assign we        = we_q;
    assign inaddr    = inaddr_q;
    assign din       = din_q;
    assign outaddr   = outaddr_q;
    assign scan_wrap = scan_wrap_q;

    // Data is not readable while the last write is still on its way into the RAM.
    assign rd_strobe = (state_q == SCAN) && dwell_tc && !we_q;

endmodule
